// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling controller.
package pool_pkg;

    localparam int DW = 13;

    typedef logic signed [DW-1:0] sample_t;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ROW_EVEN = 2'd1;
    localparam logic [1:0] S_ROW_ODD  = 2'd2;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Half-width row of horizontal maxima: synchronous write, registered read.
module pool_row_buffer #(
    parameter int DATA_W = 13,
    parameter int OW     = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rd_q
);
    // Depth is rounded up to a power of two so every address value is in range.
    localparam int DEPTH = (OW > (1 << AW)) ? OW : (1 << AW);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (clear) begin
            rd_d = '0;
        end else if (re) begin
            rd_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/pool_stride_controller.sv
// 2x2 stride-2 signed max pooling over a raster-order sample stream.
module pool_stride_controller
    import pool_pkg::*;
#(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int IMG_WIDTH        = 512,
    parameter int IMG_HEIGHT       = 512
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_clear,
    input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] i_data,
    input  logic                                     i_data_valid,
    output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] o_data,
    output logic                                     o_data_valid,
    output logic                                     o_intr,
    output logic                                     o_frame_done,
    output logic                                     o_busy
);
    localparam int DATA_W = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int OW     = IMG_WIDTH / 2;
    localparam int AW     = (OW > 1) ? $clog2(OW) : 1;
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;
    logic              o_data_valid_q, o_data_valid_d;
    logic              o_intr_q, o_intr_d;
    logic              o_frame_done_q, o_frame_done_d;
    logic              o_busy_q, o_busy_d;

    logic              buf_we, buf_re;
    logic [AW-1:0]     buf_addr;
    logic [DATA_W-1:0] buf_wdata, rd_q;
    logic              last_col, last_row;

    assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));
    assign buf_addr  = AW'(col_q >> 1);
    assign buf_wdata = smax(hold_q, i_data);

    pool_row_buffer #(
        .DATA_W (DATA_W),
        .OW     (OW),
        .AW     (AW)
    ) u_row_buffer (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (i_clear),
        .we    (buf_we),
        .waddr (buf_addr),
        .wdata (buf_wdata),
        .re    (buf_re),
        .raddr (buf_addr),
        .rd_q  (rd_q)
    );

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        hold_d         = hold_q;
        o_data_d       = o_data_q;
        o_busy_d       = o_busy_q;
        o_data_valid_d = 1'b0;
        o_intr_d       = 1'b0;
        o_frame_done_d = 1'b0;
        buf_we         = 1'b0;
        buf_re         = 1'b0;
        if (i_clear) begin
            state_d  = S_IDLE;
            col_d    = '0;
            row_d    = '0;
            hold_d   = '0;
            o_data_d = '0;
            o_busy_d = 1'b0;
        end else if (i_data_valid) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            if (last_col) begin
                row_d = last_row ? '0 : row_q + 1'b1;
            end
            if (!col_q[0]) begin
                hold_d = i_data;
            end
            // IDLE shares the even-row datapath: counters are already at row 0 / col 0.
            case (state_q)
                S_IDLE, S_ROW_EVEN: begin
                    o_busy_d = 1'b1;
                    buf_we   = col_q[0];
                    state_d  = last_col ? S_ROW_ODD : S_ROW_EVEN;
                end
                S_ROW_ODD: begin
                    buf_re = !col_q[0];
                    if (col_q[0]) begin
                        o_data_d       = smax(smax(hold_q, i_data), rd_q);
                        o_data_valid_d = 1'b1;
                    end
                    if (last_col) begin
                        o_intr_d       = 1'b1;
                        o_frame_done_d = last_row;
                        o_busy_d       = !last_row;
                        state_d        = last_row ? S_IDLE : S_ROW_EVEN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            col_q          <= '0;
            row_q          <= '0;
            hold_q         <= '0;
            o_data_q       <= '0;
            o_data_valid_q <= 1'b0;
            o_intr_q       <= 1'b0;
            o_frame_done_q <= 1'b0;
            o_busy_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            hold_q         <= hold_d;
            o_data_q       <= o_data_d;
            o_data_valid_q <= o_data_valid_d;
            o_intr_q       <= o_intr_d;
            o_frame_done_q <= o_frame_done_d;
            o_busy_q       <= o_busy_d;
        end
    end

    assign o_data       = o_data_q;
    assign o_data_valid = o_data_valid_q;
    assign o_intr       = o_intr_q;
    assign o_frame_done = o_frame_done_q;
    assign o_busy       = o_busy_q;

endmodule

// File: tb/tb_pool_stride_controller.sv
// Directed bench for pool_stride_controller: 4x4, 2x2 and 4x2 instances share clock, reset, clear and data.
module tb_pool_stride_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr;
    logic [12:0] din;
    logic        v44, v22, v42;
    logic [12:0] d44, d22, d42;
    logic        dv44, dv22, dv42, in44, in22, in42, fd44, fd22, fd42, b44, b22, b42;

    int n_cmp = 0;
    int n_err = 0;
    int n_intr, n_fd;
    int cur;

    logic [12:0] od;
    logic        ov, oi, ofd, ob;

    always_comb begin
        case (cur)
            1:       begin od = d22; ov = dv22; oi = in22; ofd = fd22; ob = b22; end
            2:       begin od = d42; ov = dv42; oi = in42; ofd = fd42; ob = b42; end
            default: begin od = d44; ov = dv44; oi = in44; ofd = fd44; ob = b44; end
        endcase
    end

    pool_stride_controller #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut44 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_data(din), .i_data_valid(v44),
        .o_data(d44), .o_data_valid(dv44), .o_intr(in44), .o_frame_done(fd44), .o_busy(b44));

    pool_stride_controller #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(2), .IMG_HEIGHT(2)) u_dut22 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_data(din), .i_data_valid(v22),
        .o_data(d22), .o_data_valid(dv22), .o_intr(in22), .o_frame_done(fd22), .o_busy(b22));

    pool_stride_controller #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(4), .IMG_HEIGHT(2)) u_dut42 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_data(din), .i_data_valid(v42),
        .o_data(d42), .o_data_valid(dv42), .o_intr(in42), .o_frame_done(fd42), .o_busy(b42));

    function automatic logic [12:0] fx(input int x);
        return 13'(x * 16);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: present a sample (or idle) and return #1 after the edge.
    task automatic cyc(input int sel, input logic [12:0] d, input logic v, input logic c);
        din = d;
        v44 = v && (sel == 0);
        v22 = v && (sel == 1);
        v42 = v && (sel == 2);
        clr = c;
        @(posedge clk);
        #1;
        v44 = 1'b0;
        v22 = 1'b0;
        v42 = 1'b0;
        clr = 1'b0;
    endtask

    task automatic frame(input int sel, input int w, input int h, input int px[$],
                         input int maxgap, input string tag);
        int m;
        int g;
        cur = sel;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                cyc(sel, fx(px[r*w+c]), 1'b1, 1'b0);
                if (r == 0 && c == 0) chk1({tag, "_busy_set"}, ob, 1'b1);
                if (r % 2 == 1 && c % 2 == 1) begin
                    m = max4(px[(r-1)*w+c-1], px[(r-1)*w+c], px[r*w+c-1], px[r*w+c]);
                    chk1({tag, "_valid"}, ov, 1'b1);
                    chkd({tag, "_data"}, od, fx(m));
                    chk1({tag, "_intr"}, oi, c == w - 1);
                    chk1({tag, "_fdone"}, ofd, (r == h - 1) && (c == w - 1));
                    if (oi) n_intr++;
                    if (ofd) n_fd++;
                end else begin
                    chk1({tag, "_novalid"}, ov, 1'b0);
                end
                g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                for (int k = 0; k < g; k++) begin
                    cyc(sel, 13'h0, 1'b0, 1'b0);
                    if (k == 0) begin
                        chk1({tag, "_gap_valid"}, ov, 1'b0);
                        chk1({tag, "_gap_intr"}, oi, 1'b0);
                    end
                end
            end
        end
        chk1({tag, "_busy_clr"}, ob, 1'b0);
    endtask

    initial begin
        int q42[$];
        int qn[$];
        int qa[$];
        int qb[$];
        q42 = {1, 5, -3, 2, 4, 0, 7, -8};
        qn  = {-1, -2, -5, -16};
        qa  = {3, -7, 12, 0, 5, 9, -2, 4, -10, -11, -12, -13, 8, -1, 6, 15};
        qb  = {-20, -30, -40, -50, -25, -35, -45, -55, 100, -100, 50, 51, -100, 99, 52, 49};

        cur = 0;
        rst = 1'b1;
        clr = 1'b0;
        din = '0;
        v44 = 1'b0;
        v22 = 1'b0;
        v42 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkd("rst_data", d44, 13'h0);
        chk1("rst_valid", dv44, 1'b0);
        chk1("rst_intr", in44, 1'b0);
        chk1("rst_fdone", fd44, 1'b0);
        chk1("rst_busy", b44, 1'b0);
        chk1("rst_busy22", b22, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        frame(2, 4, 2, q42, 0, "f4x2");
        chkd("f4x2_last", d42, 13'h070);

        frame(1, 2, 2, qn, 0, "neg");
        chkd("neg_hex", d22, 13'h1FF0);

        frame(0, 4, 4, qa, 0, "a_nogap");
        frame(0, 4, 4, qa, 5, "a_gap");

        n_intr = 0;
        n_fd   = 0;
        frame(0, 4, 4, qa, 0, "b2b_1");
        frame(0, 4, 4, qb, 0, "b2b_2");
        chki("b2b_intr_count", n_intr, 4);
        chki("b2b_fdone_count", n_fd, 2);

        cur = 0;
        for (int i = 0; i < 6; i++) cyc(0, fx(qb[i]), 1'b1, 1'b0);
        chk1("pre_rst_valid", dv44, 1'b1);
        chkd("pre_rst_data", d44, fx(-20));
        #2 rst = 1'b1;
        #1;
        chkd("async_rst_data", d44, 13'h0);
        chk1("async_rst_valid", dv44, 1'b0);
        chk1("async_rst_busy", b44, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        frame(0, 4, 4, qa, 0, "post_rst");

        for (int i = 0; i < 5; i++) cyc(0, fx(qb[i]), 1'b1, 1'b0);
        cyc(0, fx(99), 1'b1, 1'b1);
        chk1("clr_busy", b44, 1'b0);
        chkd("clr_data", d44, 13'h0);
        chk1("clr_valid", dv44, 1'b0);
        frame(0, 4, 4, qb, 0, "post_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
